// File: rtl/sync_fifo_wl_if.sv
// rtl/sync_fifo_wl_if.sv - write/read handshake bundle for sync_fifo_wl
// master drives requests and write data; slave (the FIFO) returns data, flags and water level
interface sync_fifo_wl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   water_level;

   modport master (
      output wr_data, wr_en, rd_en,
      input  full, almost_full, rd_data, empty, almost_empty, water_level
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
      output full, almost_full, rd_data, empty, almost_empty, water_level
   );
endinterface

// File: rtl/sync_fifo_wl.sv
// rtl/sync_fifo_wl.sv - single-clock distributed-RAM FIFO with FWFT/standard read, water level and flush
// optional sticky overflow/underflow flags with err_clr under SYNC_FIFO_ERR_FLAG_EN
module sync_fifo_wl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 24,
   parameter int FWFT       = 0,
   parameter int OUT_REG    = 0,
   parameter int AF_LEVEL   = 252,
   parameter int AE_LEVEL   = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_flush,
`ifdef SYNC_FIFO_ERR_FLAG_EN
   input  logic i_err_clr,
   output logic o_overflow,
   output logic o_underflow,
`endif
   sync_fifo_wl_if.slave io_fifo
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   L_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0]   L_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0]   L_CNT1  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] L_PTR1  = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [DATA_WIDTH-1:0] w_head;

   assign w_full   = (r_count == L_DEPTH);
   assign w_empty  = (r_count == '0);
   // flush wins over both requests, so neither side moves in a flush cycle
   assign w_wr_acc = io_fifo.wr_en & ~w_full  & ~i_flush;
   assign w_rd_acc = io_fifo.rd_en & ~w_empty & ~i_flush;
   assign w_head   = r_mem[r_rd_ptr];

   assign io_fifo.full         = w_full;
   assign io_fifo.empty        = w_empty;
   assign io_fifo.almost_full  = (r_count >= L_AF);
   assign io_fifo.almost_empty = (r_count <= L_AE);
   assign io_fifo.water_level  = r_count;

   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= io_fifo.wr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + L_PTR1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + L_PTR1;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + L_CNT1;
            2'b01:   r_count <= r_count - L_CNT1;
            default: r_count <= r_count;
         endcase
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign io_fifo.rd_data = w_head;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rd_data;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_rd_data <= '0;
            end else if (w_rd_acc) begin
               r_rd_data <= w_head;
            end
         end

         if (OUT_REG != 0) begin : g_oreg
            logic                  r_rd_vld;
            logic [DATA_WIDTH-1:0] r_rd_data2;

            // second stage advances only behind an accepted read, otherwise holds
            always_ff @(posedge i_clk or posedge i_rst) begin
               if (i_rst) begin
                  r_rd_vld   <= 1'b0;
                  r_rd_data2 <= '0;
               end else begin
                  r_rd_vld <= w_rd_acc;
                  if (r_rd_vld) r_rd_data2 <= r_rd_data;
               end
            end
            assign io_fifo.rd_data = r_rd_data2;
         end else begin : g_noreg
            assign io_fifo.rd_data = r_rd_data;
         end
      end
   endgenerate

`ifdef SYNC_FIFO_ERR_FLAG_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (io_fifo.wr_en & w_full)        r_overflow  <= 1'b1;
         else if (i_err_clr)                r_overflow  <= 1'b0;
         if (io_fifo.rd_en & w_empty)       r_underflow <= 1'b1;
         else if (i_err_clr)                r_underflow <= 1'b0;
      end
   end
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo_wl.sv
// tb/tb_sync_fifo_wl.sv - scoreboard bench for sync_fifo_wl: standard, FWFT and output-register builds
// shared stimulus, queue reference model; error flags checked when SYNC_FIFO_ERR_FLAG_EN is defined
module tb_sync_fifo_wl;
   localparam int AW  = 4;
   localparam int DW  = 24;
   localparam int DEP = 16;
   localparam int AF  = 12;
   localparam int AE  = 4;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [2:0]    ovf;
   logic [2:0]    unf;

   logic [DW-1:0] q[$];
   sb_t           sb_std[$];
   sb_t           sb_oreg[$];
   logic [DW-1:0] exp_std = '0;
   logic [DW-1:0] exp_oreg = '0;
   bit            exp_ovf = 0;
   bit            exp_unf = 0;
   bit            mon_en = 0;
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;

   sync_fifo_wl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
   sync_fifo_wl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
   sync_fifo_wl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

   assign if0.wr_en = wr_en;  assign if0.rd_en = rd_en;  assign if0.wr_data = wr_data;
   assign if1.wr_en = wr_en;  assign if1.rd_en = rd_en;  assign if1.wr_data = wr_data;
   assign if2.wr_en = wr_en;  assign if2.rd_en = rd_en;  assign if2.wr_data = wr_data;

   sync_fifo_wl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0), .OUT_REG(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
`ifdef SYNC_FIFO_ERR_FLAG_EN
      .i_err_clr(err_clr), .o_overflow(ovf[0]), .o_underflow(unf[0]),
`endif
      .io_fifo(if0)
   );

   sync_fifo_wl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1), .OUT_REG(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
`ifdef SYNC_FIFO_ERR_FLAG_EN
      .i_err_clr(err_clr), .o_overflow(ovf[1]), .o_underflow(unf[1]),
`endif
      .io_fifo(if1)
   );

   sync_fifo_wl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0), .OUT_REG(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_oreg (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
`ifdef SYNC_FIFO_ERR_FLAG_EN
      .i_err_clr(err_clr), .o_overflow(ovf[2]), .o_underflow(unf[2]),
`endif
      .io_fifo(if2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_flags(input string tag, input logic full, input logic af, input logic empty,
                            input logic ae, input logic [AW:0] wl);
      int cnt;
      cnt = q.size();
      chk({tag, "_water_level"}, 32'(wl), 32'(cnt));
      chk({tag, "_full"}, 32'(full), 32'(cnt == DEP));
      chk({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
      chk({tag, "_almost_full"}, 32'(af), 32'(cnt >= AF));
      chk({tag, "_almost_empty"}, 32'(ae), 32'(cnt <= AE));
   endtask

   task automatic chk_all_flags();
      chk_flags("std", if0.full, if0.almost_full, if0.empty, if0.almost_empty, if0.water_level);
      chk_flags("fwft", if1.full, if1.almost_full, if1.empty, if1.almost_empty, if1.water_level);
      chk_flags("oreg", if2.full, if2.almost_full, if2.empty, if2.almost_empty, if2.water_level);
`ifdef SYNC_FIFO_ERR_FLAG_EN
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(exp_ovf));
         chk($sformatf("underflow%0d", k), 32'(unf[k]), 32'(exp_unf));
      end
`endif
   endtask

   // monitor: retire scoreboard entries whose output cycle has arrived, then compare everything
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (sb_std.size() > 0 && sb_std[0].due <= cyc) begin
               e = sb_std.pop_front();
               exp_std = e.d;
            end
            while (sb_oreg.size() > 0 && sb_oreg[0].due <= cyc) begin
               e = sb_oreg.pop_front();
               exp_oreg = e.d;
            end
            chk_all_flags();
            chk("std_rd_data", 32'(if0.rd_data), 32'(exp_std));
            chk("oreg_rd_data", 32'(if2.rd_data), 32'(exp_oreg));
            if (q.size() > 0) chk("fwft_rd_data", 32'(if1.rd_data), 32'(q[0]));
         end
      end
   end

   task automatic step(input bit w, input bit r, input bit f, input logic [DW-1:0] d, input bit clr);
      bit full_m, empty_m, ovf_ev, unf_ev;
      logic [DW-1:0] hd;
      @(negedge clk);
      #1;
      wr_en = w; rd_en = r; flush = f; wr_data = d; err_clr = clr;
      @(posedge clk);
      full_m  = (q.size() == DEP);
      empty_m = (q.size() == 0);
      ovf_ev  = w && full_m;
      unf_ev  = r && empty_m;
      cyc++;
      if (f) begin
         q.delete();
      end else begin
         if (r && !empty_m) begin
            hd = q.pop_front();
            sb_std.push_back('{due: cyc, d: hd});
            sb_oreg.push_back('{due: cyc + 1, d: hd});
         end
         if (w && !full_m) q.push_back(d);
      end
      if (ovf_ev) exp_ovf = 1; else if (clr) exp_ovf = 0;
      if (unf_ev) exp_unf = 1; else if (clr) exp_unf = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
   endtask

   // asynchronous reset landing between clock edges; outputs must clear before the next edge
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
      q.delete(); sb_std.delete(); sb_oreg.delete();
      exp_std = '0; exp_oreg = '0; exp_ovf = 0; exp_unf = 0;
      #1;
      chk_all_flags();
      chk("rst_std_rd_data", 32'(if0.rd_data), 32'd0);
      chk("rst_oreg_rd_data", 32'(if2.rd_data), 32'd0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic rand_phase(input int n, input int wpct, input int rpct);
      for (int i = 0; i < n; i++) begin
         step($urandom_range(0, 99) < wpct, $urandom_range(0, 99) < rpct,
              $urandom_range(0, 99) < 2, DW'($urandom()), $urandom_range(0, 99) < 4);
      end
   endtask

   initial begin
      do_reset();
      mon_en = 1;
      idle(2);
      for (int i = 1; i <= DEP; i++) step(1, 0, 0, DW'(i), 0);
      step(1, 0, 0, 24'h000011, 0);
      for (int i = 0; i < DEP; i++) step(0, 1, 0, '0, 0);
      step(0, 1, 0, '0, 0);
      idle(2);
      step(0, 0, 0, '0, 1);
      idle(2);
      for (int i = 0; i < DEP; i++) step(1, 0, 0, DW'($urandom()), 0);
      step(1, 1, 0, 24'h5A5A5A, 0);
      for (int i = 0; i < DEP - 1; i++) step(0, 1, 0, '0, 0);
      step(1, 1, 0, 24'hC3C3C3, 0);
      step(0, 1, 0, '0, 0);
      idle(2);
      step(1, 0, 0, 24'hABCDEF, 0);
      idle(2);
      step(0, 1, 0, '0, 0);
      idle(3);
      for (int i = 0; i < 7; i++) step(1, 0, 0, DW'($urandom()), 0);
      step(1, 0, 1, 24'h777777, 0);
      idle(2);
      rand_phase(150, 70, 30);
      rand_phase(150, 30, 70);
      rand_phase(40, 60, 60);
      do_reset();
      idle(2);
      rand_phase(150, 65, 40);
      rand_phase(150, 35, 65);
      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
